// File: rtl/secded_pkg.sv
// Shared SEC-DED definitions: check-bit count, codeword position mapping and
// the per-word status record, used by both the decoder and the encoder.
package secded_pkg;

   localparam int POS_W_MAX = 8;

   typedef struct packed {
      logic                 sec;
      logic                 ded;
      logic [POS_W_MAX-1:0] pos;
   } status_t;

   function automatic int calc_r(input int data_w);
      int r = 1;
      while ((1 << r) < data_w + r + 1) r++;
      return r;
   endfunction

   function automatic bit is_pow2(input int x);
      return (x > 0) && ((x & (x - 1)) == 0);
   endfunction

   // Data bit k lands on the k-th non-power-of-two Hamming position.
   function automatic int data_pos(input int k);
      int seen = -1;
      int pos  = 0;
      while (seen < k) begin
         pos++;
         if (!is_pow2(pos)) seen++;
      end
      return pos;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity generator for a SEC-DED codeword.
module secded_syndrome
   import secded_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int R      = calc_r(DATA_W),
   localparam int CW_W   = DATA_W + R + 1
) (
   input  logic [CW_W-1:0] cw,
   output logic [R-1:0]    s,
   output logic            p
);

   always_comb begin
      s = '0;
      for (int i = 1; i < CW_W; i++) begin
         if (cw[i]) s = s ^ R'(i);
      end
      p = ^cw;
   end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined SEC-DED decoder with valid/ready flow control and
// saturating corrected/uncorrectable word counters.
module secded_dec_pipe
   import secded_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int CNT_W  = 16,
   localparam int R      = calc_r(DATA_W),
   localparam int CW_W   = DATA_W + R + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_cw,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sec,
   output logic              out_ded,
   output logic [R-1:0]      out_pos,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  cnt_sec,
   output logic [CNT_W-1:0]  cnt_ded
);

   logic              in_fire;
   logic              out_fire;
   logic              s2_load;
   logic              s1_full;
   logic [DATA_W-1:0] raw_data;
   logic [DATA_W-1:0] s1_data;
   logic [DATA_W-1:0] fixed_data;
   logic [R-1:0]      syn_s;
   logic [R-1:0]      s1_s;
   logic              syn_p;
   logic              s1_p;
   status_t           st_c;
   status_t           s2_st;

   secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
      .cw (in_cw),
      .s  (syn_s),
      .p  (syn_p)
   );

   // Stage 1 keeps only the payload bits; check bits are fully summarised by {s, p}.
   for (genvar k = 0; k < DATA_W; k++) begin : g_extract
      assign raw_data[k] = in_cw[data_pos(k)];
   end

   assign s2_load  = s1_full && (!out_valid || out_ready);
   assign in_ready = !s1_full || s2_load;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_full <= 1'b0;
         s1_data <= '0;
         s1_s    <= '0;
         s1_p    <= 1'b0;
      end else if (in_fire) begin
         s1_full <= 1'b1;
         s1_data <= raw_data;
         s1_s    <= syn_s;
         s1_p    <= syn_p;
      end else if (s2_load) begin
         s1_full <= 1'b0;
      end
   end

   always_comb begin
      st_c = '0;
      if (s1_p) begin
         if ({1'b0, s1_s} < (R+1)'(CW_W)) begin
            st_c.sec = 1'b1;
            st_c.pos = POS_W_MAX'(s1_s);
         end else begin
            st_c.ded = 1'b1;
         end
      end else if (s1_s != '0) begin
         st_c.ded = 1'b1;
      end
   end

   // A corrected check or parity position leaves the payload untouched.
   for (genvar k = 0; k < DATA_W; k++) begin : g_correct
      assign fixed_data[k] = s1_data[k] ^ (st_c.sec && (s1_s == R'(data_pos(k))));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         s2_st     <= '0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= fixed_data;
         s2_st     <= st_c;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_sec = s2_st.sec;
   assign out_ded = s2_st.ded;
   assign out_pos = R'(s2_st.pos);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_sec <= '0;
         cnt_ded <= '0;
      end else if (clr_cnt) begin
         cnt_sec <= '0;
         cnt_ded <= '0;
      end else if (out_fire) begin
         if (out_sec && (cnt_sec != '1)) cnt_sec <= cnt_sec + 1'b1;
         if (out_ded && (cnt_ded != '1)) cnt_ded <= cnt_ded + 1'b1;
      end
   end

endmodule
